ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
// - Execute stage, directly upstream of the MEM stage. Registers the ID->EX bus, computes the ALU result and data-SRAM address.
// - Issues the data-SRAM request and packs ex_to_mem_bus in the exact field layout MEM unpacks.
// - Contains a 32-cycle iterative divider that holds the pipeline via stallreq_ex.
// PARAMETERS
// ID_TO_EX_WD   143  ID->EX bus: {pc[142:111],alu_op[110:107],div_op[106:105],mem_en[104],mem_we[103],mem_byte[102],rf_we[101],rf_waddr[100:96],src1[95:64],src2[63:32],st_data[31:0]}
// EX_TO_MEM_WD  80   {readen[79:76],pc[75:44],ram_en[43],ram_wen[42:39],sel_rf_res[38],rf_we[37],rf_waddr[36:32],ex_result[31:0]}
// STALL_WD      6    stall bus width; bit 2 = EX, bit 3 = MEM
// PORTS
// clk             in   1    clock, rising edge
// rst             in   1    reset, asynchronous, active-high
// stall           in   6    per-stage stall, 1 = Stop
// id_to_ex_bus    in   143  decoded instruction from ID
// ex_to_mem_bus   out  80   to MEM pipeline register
// ex_to_id        out  38   forwarding {rf_we,rf_waddr,ex_result}
// ex_is_load      out  1    EX holds a load (ID uses it for load-use stall)
// stallreq_ex     out  1    divider busy; stall controller freezes IF..EX
// data_sram_en    out  1    SRAM access enable
// data_sram_wen   out  4    byte write enables
// data_sram_addr  out  32   byte address
// data_sram_wdata out  32   write data
// hi_o, lo_o      out  32   divide remainder / quotient
// hilo_we         out  1    one-cycle pulse, hi_o/lo_o valid
// BEHAVIOUR
// - Input register: async reset to 0. If stall[2]=Stop and stall[3]=NoStop, load 0 (bubble). Else if stall[2]=NoStop, load id_to_ex_bus. Else hold.
// - A zero register is a bubble: all outputs 0, no SRAM access.
// - ALU (combinational, 32-bit wrap):
//   - 0 add, 1 sub, 2 and, 3 or, 4 xor
//   - 5 sll, 6 srl, 7 sra: shift amount src1[4:0], shifted operand src2
//   - 8 slt signed, 9 sltu, 10 lui = {src2[15:0],16'b0}, 11 pass src2
//   - 12-15 produce 0
// - Memory (mem_en=1): addr = src1+src2.
//   - Load: ram_en=1, wen=0000, readen=1111 (word) or 0001 (byte), sel_rf_res=1.
//   - Store: word wen=1111, wdata=st_data. Byte wen=4'b0001<<addr[1:0], wdata={4{st_data[7:0]}}; readen=0.
//   - Word access with addr[1:0]!=0: request issued unmodified; no exception.
//   - ex_result = addr, so MEM selects the byte lane from ex_result[1:0].
// - A held EX instruction re-issues the same SRAM request each cycle (idempotent).
// - Divider FSM {IDLE,BUSY,DONE}, cnt[5:0]; div_op: [1]=divide, [0]=signed.
//   - IDLE & div_op[1]:
//     - divisor==0: go to DONE with quotient 32'hFFFF_FFFF, remainder = dividend (1 stall cycle).
//     - else: latch |src1|,|src2| (signed) or raw values, record result signs, cnt=0, go to BUSY.
//   - BUSY: one restoring shift-subtract step per cycle. Go to DONE after cnt==31.
//   - DONE: quotient negated if operand signs differ; remainder takes dividend sign.
//   - stallreq_ex=1 in IDLE(div pending) and BUSY, 0 in DONE. Signed div occupies EX for 34 cycles (33 stall).
//   - DONE: ex_result=quotient, hilo_we=1 for one cycle. Return to IDLE on the first cycle stall[2]=NoStop; hold DONE while stalled.
//   - -2^31 / -1: quotient 32'h8000_0000, remainder 0.
// - Reset mid-divide: FSM -> IDLE, cnt -> 0, all outputs 0 immediately (async).
// - ex_is_load = mem_en & ~mem_we. ex_to_id carries the same rf_we/rf_waddr/ex_result sent to MEM.
// CONFIGURATION
// - DIV_EN defined: divider as above.
// - DIV_EN undefined: no divider logic. div_op ignored, stallreq_ex=0, hilo_we=0, hi_o=lo_o=0. A div instruction writes ex_result=0.
// TESTING
// - add src1=5,src2=-3, rf_waddr=4 -> ex_result=2, ex_to_id={1,4,2}, data_sram_en=0.
// - byte store src1=0x100,src2=2, st_data=0xAB -> addr 0x102, wen=0100, wdata=0xABABABAB, readen=0.
// - signed div -7/2 -> stallreq_ex high 33 cycles, then lo_o=-3, hi_o=-1, hilo_we single pulse.
// - divu 9/0 -> 1 stall cycle, lo_o=0xFFFFFFFF, hi_o=9.
// - stall=6'b000111 -> next EX register is bubble; stall=6'b001111 -> EX contents held, SRAM request repeated.
// - rst pulsed at BUSY cnt=10 -> stallreq_ex=0 and outputs 0 before the next edge. A new div then completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage sitting between ID and MEM.
// Registers the ID->EX bus, evaluates the ALU, forms the data-SRAM request
// and packs ex_to_mem_bus in the layout MEM unpacks.
// Optional 32-cycle iterative divider is built only when DIV_EN is defined;
// without it div_op has no effect beyond zeroing the result of a div.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 143,
  parameter int EX_TO_MEM_WD = 80,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id,
  output logic                    ex_is_load,
  output logic                    stallreq_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic                    hilo_we
);

  logic [ID_TO_EX_WD-1:0] exBus_q, exBus_d;
  logic [31:0] pc, src1, src2, stData;
  logic [3:0]  aluOp;
  logic [1:0]  divOp;
  logic        memEn, memWe, memByte, rfWe;
  logic [4:0]  rfWaddr;

  assign {pc, aluOp, divOp, memEn, memWe, memByte, rfWe, rfWaddr,
          src1, src2, stData} = exBus_q;

  // EX pipeline register: bubble when EX stops but MEM runs, hold when both stop
  always_comb begin
    exBus_d = exBus_q;
    if (stall[2] && !stall[3]) begin
      exBus_d = '0;
    end else if (!stall[2]) begin
      exBus_d = id_to_ex_bus;
    end
  end

  // EX pipeline register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exBus_q <= '0;
    else     exBus_q <= exBus_d;
  end

  logic [31:0] aluResult;

  // ALU: shifts take the amount from src1 and shift src2
  always_comb begin
    aluResult = '0;
    case (aluOp)
      4'd0:    aluResult = src1 + src2;
      4'd1:    aluResult = src1 - src2;
      4'd2:    aluResult = src1 & src2;
      4'd3:    aluResult = src1 | src2;
      4'd4:    aluResult = src1 ^ src2;
      4'd5:    aluResult = src2 << src1[4:0];
      4'd6:    aluResult = src2 >> src1[4:0];
      4'd7:    aluResult = $signed(src2) >>> src1[4:0];
      4'd8:    aluResult = {31'b0, $signed(src1) < $signed(src2)};
      4'd9:    aluResult = {31'b0, src1 < src2};
      4'd10:   aluResult = {src2[15:0], 16'b0};
      4'd11:   aluResult = src2;
      default: aluResult = '0;
    endcase
  end

  logic [31:0] memAddr, sramAddr, sramWdata;
  logic [3:0]  sramWen, readEn;
  logic        selRfRes;

  // Data-SRAM request; misaligned word accesses go out unmodified
  always_comb begin
    memAddr   = src1 + src2;
    sramAddr  = '0;
    sramWen   = '0;
    sramWdata = '0;
    readEn    = '0;
    selRfRes  = 1'b0;
    if (memEn) begin
      sramAddr = memAddr;
      if (memWe) begin
        if (memByte) begin
          sramWen   = 4'b0001 << memAddr[1:0];
          sramWdata = {4{stData[7:0]}};
        end else begin
          sramWen   = 4'b1111;
          sramWdata = stData;
        end
      end else begin
        readEn   = memByte ? 4'b0001 : 4'b1111;
        selRfRes = 1'b1;
      end
    end
  end

  logic [31:0] divResult;
  logic        unusedStall;
  assign unusedStall = ^{stall[STALL_WD-1:4], stall[1:0]};

`ifdef DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_t;
  divState_t   divState_q, divState_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        qNeg_q, qNeg_d, rNeg_q, rNeg_d;
  logic [32:0] trial;
  logic [31:0] quoFinal, remFinal;

  // Divider next state: latch magnitudes, then one restoring step per cycle
  always_comb begin
    divState_d = divState_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    qNeg_d     = qNeg_q;
    rNeg_d     = rNeg_q;
    trial      = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    case (divState_q)
      DIV_IDLE: begin
        if (divOp[1]) begin
          if (src2 == '0) begin
            quo_d      = '1;
            rem_d      = src1;
            qNeg_d     = 1'b0;
            rNeg_d     = 1'b0;
            divState_d = DIV_DONE;
          end else begin
            quo_d      = (divOp[0] && src1[31]) ? -src1 : src1;
            dvs_d      = (divOp[0] && src2[31]) ? -src2 : src2;
            rem_d      = '0;
            qNeg_d     = divOp[0] & (src1[31] ^ src2[31]);
            rNeg_d     = divOp[0] & src1[31];
            cnt_d      = '0;
            divState_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) divState_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!stall[2]) divState_d = DIV_IDLE;
      end
      default: divState_d = DIV_IDLE;
    endcase
  end

  // Divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divState_q <= DIV_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      qNeg_q     <= 1'b0;
      rNeg_q     <= 1'b0;
    end else begin
      divState_q <= divState_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      qNeg_q     <= qNeg_d;
      rNeg_q     <= rNeg_d;
    end
  end

  // Sign fix-up and result/handshake outputs; hilo_we fires on the cycle DONE releases
  always_comb begin
    quoFinal    = qNeg_q ? -quo_q : quo_q;
    remFinal    = rNeg_q ? -rem_q : rem_q;
    stallreq_ex = (divState_q == DIV_BUSY) || (divState_q == DIV_IDLE && divOp[1]);
    hilo_we     = (divState_q == DIV_DONE) && !stall[2];
    lo_o        = (divState_q == DIV_DONE) ? quoFinal : '0;
    hi_o        = (divState_q == DIV_DONE) ? remFinal : '0;
    divResult   = lo_o;
  end
`else
  logic unusedDivSign;
  assign unusedDivSign = divOp[0];
  assign stallreq_ex   = 1'b0;
  assign hilo_we       = 1'b0;
  assign hi_o          = '0;
  assign lo_o          = '0;
  assign divResult     = '0;
`endif

  logic [31:0] exResult;

  // Result select and output packing; memory ops report the address for lane select in MEM
  always_comb begin
    exResult        = memEn ? memAddr : (divOp[1] ? divResult : aluResult);
    data_sram_en    = memEn;
    data_sram_wen   = sramWen;
    data_sram_addr  = sramAddr;
    data_sram_wdata = sramWdata;
    ex_is_load      = memEn & ~memWe;
    ex_to_id        = {rfWe, rfWaddr, exResult};
    ex_to_mem_bus   = {readEn, pc, memEn, sramWen, selRfRes, rfWe, rfWaddr, exResult};
  end

endmodule
